// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// The starvation guard is enabled by defining WB_STARVE_GUARD_EN.
package rf_wb_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NREGS    = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0]   rd;
        logic [XLEN_DEF-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_LD
    } grant_e;

    // x0 is hardwired, so it is never considered pending.
    function automatic logic pend_hit(input logic [NREGS-1:0]  pend,
                                      input logic [REG_AW-1:0] rs);
        return (rs != '0) && pend[rs];
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Small power-of-two FIFO buffering cache load returns ahead of writeback.
// Caller guarantees no push when full and no pop when empty.
module wb_load_fifo #(
    parameter int unsigned W     = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [W-1:0]  mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; an empty count already makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU vs buffered load returns, plus a load scoreboard.
// Define WB_STARVE_GUARD_EN to let a waiting load win after STARVE_MAX consecutive ALU wins.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned LDQ_DEPTH  = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memhazard,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,
    input  logic              iss_ld_valid,
    input  logic [REG_AW-1:0] iss_ld_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              raw_stall,
    output logic              wena,
    output logic [REG_AW-1:0] wrd,
    output logic [XLEN-1:0]   wdata
);

    localparam int unsigned EW = REG_AW + XLEN;

    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [EW-1:0]     fifo_head;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_data;
    logic              force_ld;
    grant_e            grant;
    logic [NREGS-1:0]  pending_q, pending_d;

    // Load returns always go through the FIFO, so a write is never earlier than the cycle after push.
    assign ld_ready  = !fifo_full;
    assign fifo_push = ld_valid && ld_ready;

    wb_load_fifo #(
        .W     (EW),
        .DEPTH (LDQ_DEPTH)
    ) u_ldq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  ({ld_rd, ld_data}),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign head_rd   = fifo_head[XLEN +: REG_AW];
    assign head_data = fifo_head[XLEN-1:0];

    assign alu_ready = !memhazard && !force_ld;

    // NOTE: combinational blocks assign a default first and use blocking '=', so no latch is inferred.
    always_comb begin
        grant = GNT_NONE;
        if (!memhazard) begin
            if (alu_valid && !force_ld) grant = GNT_ALU;
            else if (!fifo_empty)       grant = GNT_LD;
        end
    end

    assign fifo_pop = (grant == GNT_LD);

    always_comb begin
        wrd   = '0;
        wdata = '0;
        unique case (grant)
            GNT_ALU: begin
                wrd   = alu_rd;
                wdata = alu_data;
            end
            GNT_LD: begin
                wrd   = head_rd;
                wdata = head_data;
            end
            default: ;
        endcase
    end

    // rd=0 commits still complete the handshake or pop, but never write.
    assign wena = (grant != GNT_NONE) && (wrd != '0);

    // The set is applied after the clear, so a same-cycle reissue keeps the bit pending.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop && (head_rd != '0))          pending_d[head_rd]   = 1'b0;
        if (iss_ld_valid && (iss_ld_rd != '0))    pending_d[iss_ld_rd] = 1'b1;
    end

    // NOTE: state registers update only with non-blocking '<=' so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign raw_stall = pend_hit(pending_q, rs1) || pend_hit(pending_q, rs2);

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign force_ld = (starve_q >= CNT_W'(STARVE_MAX)) && !fifo_empty;

    always_comb begin
        starve_d = starve_q;
        if (fifo_pop)                              starve_d = '0;
        else if ((grant == GNT_ALU) && !fifo_empty) starve_d = starve_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`else
    assign force_ld = 1'b0;

    // Strict ALU priority leaves the starvation limit without a consumer.
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter; expectations follow WB_STARVE_GUARD_EN when defined.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memhazard;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        iss_ld_valid;
    logic [4:0]  iss_ld_rd;
    logic [4:0]  rs1, rs2;
    logic        raw_stall;
    logic        wena;
    logic [4:0]  wrd;
    logic [31:0] wdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memhazard    (memhazard),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .ld_valid     (ld_valid),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .iss_ld_valid (iss_ld_valid),
        .iss_ld_rd    (iss_ld_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .raw_stall    (raw_stall),
        .wena         (wena),
        .wrd          (wrd),
        .wdata        (wdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        memhazard    = 1'b0;
        alu_valid    = 1'b0;
        alu_rd       = '0;
        alu_data     = '0;
        ld_valid     = 1'b0;
        ld_rd        = '0;
        ld_data      = '0;
        iss_ld_valid = 1'b0;
        iss_ld_rd    = '0;
        rs1          = '0;
        rs2          = '0;
    endtask

    task automatic expect_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
        check({tag, "_wena"},  wena,  1'b1);
        check({tag, "_wrd"},   wrd,   rd);
        check({tag, "_wdata"}, wdata, data);
    endtask

    initial begin
        logic exp_ld;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_wena",     wena,      1'b0);
        check("rst_raw",      raw_stall, 1'b0);
        check("rst_ld_ready", ld_ready,  1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single load return: no bypass, written the following cycle.
        @(negedge clk);
        ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hA5;
        #1;
        check("ld1_ready",    ld_ready, 1'b1);
        check("ld1_nobypass", wena,     1'b0);
        @(negedge clk);
        clear_inputs();
        #1;
        expect_write("ld1", 5'd5, 32'hA5);
        @(negedge clk);
        #1;
        check("ld1_drained", wena, 1'b0);

        // Scoreboard set on issue, cleared after the load commits.
        @(negedge clk);
        iss_ld_valid = 1'b1; iss_ld_rd = 5'd7; rs1 = 5'd7;
        #1;
        check("raw_before_set", raw_stall, 1'b0);
        @(negedge clk);
        iss_ld_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        #1;
        check("raw_pending", raw_stall, 1'b1);
        check("raw_no_wr",   wena,      1'b0);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        expect_write("ld7", 5'd7, 32'h77);
        check("raw_during_commit", raw_stall, 1'b1);
        @(negedge clk);
        #1;
        check("raw_cleared", raw_stall, 1'b0);

        // ALU writes to x0 and issues to x0 have no architectural effect.
        @(negedge clk);
        clear_inputs();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        iss_ld_valid = 1'b1; iss_ld_rd = 5'd0;
        #1;
        check("x0_wena",      wena,      1'b0);
        check("x0_alu_ready", alu_ready, 1'b1);
        @(negedge clk);
        iss_ld_valid = 1'b0;
        alu_rd = 5'd9; alu_data = 32'h1234; rs1 = 5'd7; rs2 = 5'd5;
        #1;
        expect_write("alu9", 5'd9, 32'h1234);
        check("x0_no_pending", raw_stall, 1'b0);

        // Reissue to rd=3 in the cycle its previous load commits keeps it pending.
        @(negedge clk);
        clear_inputs();
        rs1 = 5'd3;
        iss_ld_valid = 1'b1; iss_ld_rd = 5'd3;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        #1;
        check("sw_raw0", raw_stall, 1'b0);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        expect_write("sw_ld3", 5'd3, 32'h33);
        check("sw_raw1", raw_stall, 1'b1);
        @(negedge clk);
        iss_ld_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h34;
        #1;
        check("sw_set_wins", raw_stall, 1'b1);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        expect_write("sw_ld3b", 5'd3, 32'h34);
        @(negedge clk);
        #1;
        check("sw_cleared", raw_stall, 1'b0);

        // Two loads buffered under memhazard, then ALU held valid continuously.
        @(negedge clk);
        clear_inputs();
        memhazard = 1'b1;
        ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h20;
        #1;
        check("stv_pre0_wena", wena, 1'b0);
        @(negedge clk);
        ld_rd = 5'd21; ld_data = 32'h21;
        #1;
        check("stv_pre1_wena", wena, 1'b0);
        @(negedge clk);
        clear_inputs();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        for (int i = 0; i < 5; i++) begin
            #1;
`ifdef WB_STARVE_GUARD_EN
            exp_ld = (i == 3);
`else
            exp_ld = 1'b0;
`endif
            check($sformatf("stv%0d_alu_ready", i), alu_ready, !exp_ld);
            check($sformatf("stv%0d_wrd", i),       wrd,       exp_ld ? 5'd20 : 5'd1);
            check($sformatf("stv%0d_wdata", i),     wdata,     exp_ld ? 32'h20 : 32'hA1);
            @(negedge clk);
        end
        alu_valid = 1'b0;
        #1;
`ifndef WB_STARVE_GUARD_EN
        expect_write("stv_drain20", 5'd20, 32'h20);
        @(negedge clk);
        #1;
`endif
        expect_write("stv_drain21", 5'd21, 32'h21);
        @(negedge clk);
        #1;
        check("stv_empty", wena, 1'b0);

        // memhazard for 4 cycles: no writes, FIFO fills, third load is held off.
        @(negedge clk);
        clear_inputs();
        memhazard = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h10;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_rd    = (i == 0) ? 5'd11 : (i == 1) ? 5'd12 : 5'd13;
            ld_data  = (i == 0) ? 32'hB : (i == 1) ? 32'hC : 32'hD;
            #1;
            check($sformatf("mh%0d_wena", i),      wena,      1'b0);
            check($sformatf("mh%0d_alu_ready", i), alu_ready, 1'b0);
            check($sformatf("mh%0d_ld_ready", i),  ld_ready,  i < 2);
            @(negedge clk);
        end
        memhazard = 1'b0;
        #1;
        expect_write("mh_alu", 5'd10, 32'h10);
        check("mh_alu_ready", alu_ready, 1'b1);
        check("mh_full_hold", ld_ready,  1'b0);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        expect_write("mh_ld11", 5'd11, 32'hB);
        check("mh_still_full", ld_ready, 1'b0);
        @(negedge clk);
        #1;
        expect_write("mh_ld12", 5'd12, 32'hC);
        check("mh_accept13", ld_ready, 1'b1);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        expect_write("mh_ld13", 5'd13, 32'hD);
        @(negedge clk);
        #1;
        check("mh_empty", wena, 1'b0);

        // Reset mid-operation drops the buffered load and its pending bit.
        @(negedge clk);
        clear_inputs();
        iss_ld_valid = 1'b1; iss_ld_rd = 5'd6;
        ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h66;
        @(negedge clk);
        clear_inputs();
        rs1 = 5'd6;
        #1;
        check("mr_pre_raw",  raw_stall, 1'b1);
        check("mr_pre_wena", wena,      1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_wena",     wena,      1'b0);
        check("mr_raw",      raw_stall, 1'b0);
        check("mr_ld_ready", ld_ready,  1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_post0_wena", wena, 1'b0);
        @(negedge clk);
        #1;
        check("mr_post1_wena", wena,      1'b0);
        check("mr_post1_raw",  raw_stall, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
